// File: rtl/trigger_detector.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_detector
//  Description : Qualifies 802.11b packets from an asynchronous envelope
//                comparator. After a minimum envelope duration it skips the
//                PLCP preamble, then raises trigger_signal for the payload
//                window. A holdoff stops retriggering inside one packet.
//                Optional macro TRIGGER_COUNT_EN builds a saturating count of
//                accepted packets on trig_count; otherwise it is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_detector #(
    parameter int QUAL_CYCLES    = 8,
    parameter int SKIP_CYCLES    = 1920,
    parameter int DROP_CYCLES    = 4,
    parameter int MAX_ACTIVE     = 20000,
    parameter int HOLDOFF_CYCLES = 100,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             env_in,
    output logic             trigger_signal,
    output logic             busy,
    output logic [CNT_W-1:0] trig_count
);

    // Counter widths leave one spare bit so a count can reach its limit.
    localparam int c_QW = $clog2(QUAL_CYCLES) + 1;
    localparam int c_SW = $clog2(SKIP_CYCLES) + 1;
    localparam int c_DW = $clog2(DROP_CYCLES) + 1;
    localparam int c_AW = $clog2(MAX_ACTIVE) + 1;
    localparam int c_HW = $clog2(HOLDOFF_CYCLES) + 1;

    localparam logic [c_QW-1:0] c_QUAL_END = c_QW'(QUAL_CYCLES);
    localparam logic [c_SW-1:0] c_SKIP_END = c_SW'(SKIP_CYCLES);
    localparam logic [c_DW-1:0] c_DROP_END = c_DW'(DROP_CYCLES);
    localparam logic [c_AW-1:0] c_ACT_END  = c_AW'(MAX_ACTIVE);
    localparam logic [c_HW-1:0] c_HOLD_END = c_HW'(HOLDOFF_CYCLES);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_QUALIFY = 3'd1;
    localparam logic [2:0] c_ST_DELAY   = 3'd2;
    localparam logic [2:0] c_ST_ACTIVE  = 3'd3;
    localparam logic [2:0] c_ST_HOLDOFF = 3'd4;

    logic            r_sync1;
    logic            r_env_s;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_QW-1:0] r_qual_cnt;
    logic [c_SW-1:0] r_skip_cnt;
    logic [c_DW-1:0] r_drop_cnt;
    logic [c_AW-1:0] r_act_cnt;
    logic [c_HW-1:0] r_hold_cnt;
    logic            r_trigger;
    logic            r_busy;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_env_s <= 1'b0;
        end else begin
            r_sync1 <= env_in;
            r_env_s <= r_sync1;
        end
    end

    // Next-state decision; each count is acted on the edge after it reaches
    // its limit, so every state lasts exactly its parameter in cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_env_s) w_state_nxt = c_ST_QUALIFY;
            end
            c_ST_QUALIFY: begin
                if (r_qual_cnt == c_QUAL_END) w_state_nxt = c_ST_DELAY;
                else if (!r_env_s)           w_state_nxt = c_ST_IDLE;
            end
            c_ST_DELAY: begin
                // A drop inside the preamble aborts without triggering.
                if (r_drop_cnt == c_DROP_END)      w_state_nxt = c_ST_HOLDOFF;
                else if (r_skip_cnt == c_SKIP_END) w_state_nxt = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if ((r_drop_cnt == c_DROP_END) || (r_act_cnt == c_ACT_END))
                    w_state_nxt = c_ST_HOLDOFF;
            end
            c_ST_HOLDOFF: begin
                // Wait for the envelope to go away so one packet never retriggers.
                if ((r_hold_cnt == c_HOLD_END) && !r_env_s) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (!enable) w_state_nxt = c_ST_IDLE;
    end

    // State, per-state counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_qual_cnt <= '0;
            r_skip_cnt <= '0;
            r_drop_cnt <= '0;
            r_act_cnt  <= '0;
            r_hold_cnt <= '0;
            r_trigger  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_trigger <= (w_state_nxt == c_ST_ACTIVE);
            r_busy    <= (w_state_nxt != c_ST_IDLE);

            if (w_state_nxt == c_ST_QUALIFY)
                r_qual_cnt <= (r_state == c_ST_QUALIFY) ? r_qual_cnt + c_QW'(1) : c_QW'(1);
            else
                r_qual_cnt <= '0;

            if (w_state_nxt == c_ST_DELAY)
                r_skip_cnt <= (r_state == c_ST_DELAY) ? r_skip_cnt + c_SW'(1) : c_SW'(1);
            else
                r_skip_cnt <= '0;

            // Consecutive low samples; spans DELAY into ACTIVE, any high restarts it.
            if ((w_state_nxt == c_ST_DELAY) || (w_state_nxt == c_ST_ACTIVE)) begin
                if (r_env_s)
                    r_drop_cnt <= '0;
                else if (r_drop_cnt != c_DROP_END)
                    r_drop_cnt <= r_drop_cnt + c_DW'(1);
            end else begin
                r_drop_cnt <= '0;
            end

            if (w_state_nxt == c_ST_ACTIVE)
                r_act_cnt <= (r_state == c_ST_ACTIVE) ? r_act_cnt + c_AW'(1) : c_AW'(1);
            else
                r_act_cnt <= '0;

            if (w_state_nxt == c_ST_HOLDOFF) begin
                if (r_state != c_ST_HOLDOFF)
                    r_hold_cnt <= c_HW'(1);
                else if (r_hold_cnt != c_HOLD_END)
                    r_hold_cnt <= r_hold_cnt + c_HW'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign trigger_signal = r_trigger;
    assign busy           = r_busy;

`ifdef TRIGGER_COUNT_EN
    logic [CNT_W-1:0] r_trig_count;

    // Saturating count of ACTIVE entries; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_trig_count <= '0;
        end else if ((w_state_nxt == c_ST_ACTIVE) && (r_state != c_ST_ACTIVE) &&
                     (r_trig_count != {CNT_W{1'b1}})) begin
            r_trig_count <= r_trig_count + CNT_W'(1);
        end
    end

    assign trig_count = r_trig_count;
`else
    assign trig_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trigger_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigger_detector
//  Description : Directed scoreboard bench for trigger_detector. Stimulus
//                pushes the expected output changes (cycle, trigger, busy,
//                count); a monitor pops one entry on every output change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_detector;

    localparam int c_CW = 4;
`ifdef TRIGGER_COUNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic            env_in;
    logic            trigger_signal;
    logic            busy;
    logic [c_CW-1:0] trig_count;

    trigger_detector #(
        .QUAL_CYCLES    (4),
        .SKIP_CYCLES    (10),
        .DROP_CYCLES    (3),
        .MAX_ACTIVE     (50),
        .HOLDOFF_CYCLES (5),
        .CNT_W          (c_CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .env_in         (env_in),
        .trigger_signal (trigger_signal),
        .busy           (busy),
        .trig_count     (trig_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic trig;
        logic busy;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   req_rst_chk = 1'b0;
    bit   req_finish = 1'b0;
    int   t0;

    function automatic int ecnt(int n);
        if (!c_CNT_EN) return 0;
        return (n > 15) ? 15 : n;
    endfunction

    // Expected change observed at the negedge after edge k, counted from t0.
    task automatic push(int k, logic t, logic b, int n);
        exp_t e;
        e.cyc  = t0 + 1 + k;
        e.trig = t;
        e.busy = b;
        e.cnt  = ecnt(n);
        sb.push_back(e);
    endtask

    task automatic hold_env(logic v, int n);
        env_in = v;
        repeat (n) @(negedge clock);
    endtask

    // Monitor: pops one expected entry per observed output change.
    initial begin : monitor
        exp_t e;
        logic            p_trig;
        logic            p_busy;
        logic [c_CW-1:0] p_cnt;
        bit              rst_done;
        rst_done = 1'b0;
        p_trig = 1'b0;
        p_busy = 1'b0;
        p_cnt  = '0;
        forever begin
            @(negedge clock);
            if (req_rst_chk && !rst_done) begin
                rst_done = 1'b1;
                checks += 3;
                if (trigger_signal !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_trigger got=%b required=0", trigger_signal);
                end
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_busy got=%b required=0", busy);
                end
                if (trig_count !== '0) begin
                    errors++;
                    $display("FAIL reset_count got=%0d required=0", trig_count);
                end
            end
            if (mon_en && (trigger_signal !== p_trig || busy !== p_busy || trig_count !== p_cnt)) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got trig=%b busy=%b cnt=%0d required no change",
                             cyc, trigger_signal, busy, trig_count);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.trig !== trigger_signal || e.busy !== busy ||
                        e.cnt != int'(trig_count)) begin
                        errors++;
                        $display("FAIL output_event got trig=%b busy=%b cnt=%0d at cyc %0d, required trig=%b busy=%b cnt=%0d at cyc %0d",
                                 trigger_signal, busy, trig_count, cyc, e.trig, e.busy, e.cnt, e.cyc);
                    end
                end
            end
            p_trig = trigger_signal;
            p_busy = busy;
            p_cnt  = trig_count;
            if (req_finish) begin
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL missing_events got=%0d pending, required=0 (next at cyc %0d)",
                             sb.size(), sb[0].cyc);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    // Stimulus.
    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        env_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        req_rst_chk = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clock);

        // Glitch: 3 high cycles never qualify.
        t0 = cyc;
        push(2, 0, 1, 0);
        push(5, 0, 0, 0);
        hold_env(1'b1, 3);
        hold_env(1'b0, 15);

        // Preamble abort: drop during DELAY goes through HOLDOFF, no trigger.
        t0 = cyc;
        push(2, 0, 1, 0);
        push(18, 0, 0, 0);
        hold_env(1'b1, 8);
        hold_env(1'b0, 25);

        // Normal packet.
        t0 = cyc;
        push(2, 0, 1, 0);
        push(16, 1, 1, 1);
        push(45, 0, 1, 1);
        push(50, 0, 0, 1);
        hold_env(1'b1, 40);
        hold_env(1'b0, 20);

        // Timeout: trigger held 50 cycles, HOLDOFF until the envelope ends.
        t0 = cyc;
        push(2, 0, 1, 1);
        push(16, 1, 1, 2);
        push(66, 0, 1, 2);
        push(202, 0, 0, 2);
        hold_env(1'b1, 200);
        hold_env(1'b0, 20);

        // Enable dropped in ACTIVE, requalify, then reset in ACTIVE.
        t0 = cyc;
        push(2, 0, 1, 2);
        push(16, 1, 1, 3);
        push(20, 0, 0, 3);
        push(21, 0, 1, 3);
        push(35, 1, 1, 4);
        push(40, 0, 0, 0);
        hold_env(1'b1, 20);
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        repeat (19) @(negedge clock);
        reset  = 1'b1;
        env_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // Saturation: 17 back-to-back packets.
        for (int k = 1; k <= 17; k++) begin
            t0 = cyc;
            push(2, 0, 1, k - 1);
            push(16, 1, 1, k);
            push(45, 0, 1, k);
            push(50, 0, 0, k);
            hold_env(1'b1, 40);
            hold_env(1'b0, 10);
        end
        repeat (20) @(negedge clock);

        req_finish = 1'b1;
        repeat (5) @(negedge clock);
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/trigger_detector.md
Name: trigger_detector

Overview:
- Upstream stage of the backscatter modulator top; generates its `trigger_signal` input.
- Synchronizes the envelope-detector comparator output and qualifies a real 802.11b packet by minimum envelope duration.
- Skips the PLCP preamble, then holds `trigger_signal` high for the payload window so the modulator only flips phase over data symbols.
- A holdoff prevents retriggering inside the same packet.

Parameters:
- QUAL_CYCLES, 8: consecutive synchronized-high samples needed to accept a packet start.
- SKIP_CYCLES, 1920: cycles waited after qualification before asserting the trigger (preamble skip).
- DROP_CYCLES, 4: consecutive synchronized-low samples that end a packet.
- MAX_ACTIVE, 20000: maximum cycles `trigger_signal` may stay high.
- HOLDOFF_CYCLES, 100: minimum dead time after a packet before re-arming.
- CNT_W, 16: width of `trig_count`.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, forces IDLE and blocks triggering.
- env_in  in  1  asynchronous envelope comparator output.
- trigger_signal  out  1  registered; high during the payload window.
- busy  out  1  registered; high in any state other than IDLE.
- trig_count  out  CNT_W  number of accepted packets (see Optional Feature).

Behaviour:
- Synchronizer:
  - `env_in` passes through 2 flops; `env_s` is the second flop.
  - Both flops reset to 0.
- Reset:
  - state = IDLE; all counters = 0.
  - `trigger_signal`, `busy` and `trig_count` = 0.
- States: IDLE, QUALIFY, DELAY, ACTIVE, HOLDOFF.
- IDLE:
  - `env_s` = 1 → QUALIFY, with qualify count = 1.
- QUALIFY:
  - `env_s` = 0 → IDLE; the count is discarded.
  - Count reaches QUAL_CYCLES → DELAY.
- DELAY:
  - Counts SKIP_CYCLES, then → ACTIVE.
  - `env_s` low for DROP_CYCLES consecutive cycles → HOLDOFF. This is an abort: no trigger is issued and the counter does not increment.
- ACTIVE:
  - `trigger_signal` = 1.
  - Exits to HOLDOFF on DROP_CYCLES consecutive low samples, or after MAX_ACTIVE cycles in ACTIVE, whichever comes first.
  - A single low sample followed by a high sample restarts the drop count.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES.
  - Returns to IDLE only once the count is complete and `env_s` = 0. If the envelope is still high, it stays in HOLDOFF, so a long or truncated packet never retriggers.
- Output registers:
  - `trigger_signal` is registered as (next_state == ACTIVE); it is glitch-free and aligned with the state.
  - `busy` is registered as (next_state != IDLE).
- Latency:
  - `env_in` rises and stays high: `trigger_signal` rises exactly 2 + QUAL_CYCLES + SKIP_CYCLES clocks after the first rising edge that samples `env_in` high.
  - `env_in` falls: `trigger_signal` falls exactly 2 + DROP_CYCLES clocks later.
- enable:
  - `enable` = 0 in any state → IDLE on the next edge; counters clear and `trigger_signal` = 0 on that edge.
  - The synchronizer keeps running.
  - Priority: reset > enable > FSM transitions.
- Simultaneous events in ACTIVE: if the MAX_ACTIVE timeout and drop detection coincide, the result is a single exit to HOLDOFF.
- Counters are sized by $clog2 of their parameter + 1; none wraps.

Optional Feature:
- Macro: TRIGGER_COUNT_EN.
- Defined:
  - `trig_count` increments by 1 on every entry to ACTIVE and saturates at 2^CNT_W-1.
  - It clears only on reset; `enable` does not clear it.
- Undefined:
  - The counter is not built; `trig_count` is tied to 0.
  - All other behaviour is identical.

Test Plan (overrides QUAL_CYCLES=4, SKIP_CYCLES=10, DROP_CYCLES=3, HOLDOFF_CYCLES=5, MAX_ACTIVE=50, CNT_W=4, TRIGGER_COUNT_EN defined):
- Normal packet:
  - Stimulus: after reset, `env_in` = 1 for 40 cycles, then 0.
  - Expected: `trigger_signal` rises 16 cycles after `env_in` is first sampled high and falls 5 cycles after `env_in` falls; `trig_count` = 1; `busy` returns to 0 after holdoff.
- Glitch rejection:
  - Stimulus: `env_in` high for 3 cycles, then low.
  - Expected: `trigger_signal` stays 0; `busy` pulses and returns to 0; `trig_count` = 0.
- Preamble abort:
  - Stimulus: `env_in` high for 8 cycles, then low for 3+ cycles, so the drop occurs during DELAY.
  - Expected: no trigger; FSM passes through HOLDOFF to IDLE; `trig_count` = 0.
- Timeout and no retrigger:
  - Stimulus: `env_in` held high for 200 cycles.
  - Expected: `trigger_signal` high for exactly 50 cycles, then 0 for the rest of the high period; only one trigger; `trig_count` = 1.
- Enable and reset mid-packet:
  - Stimulus: deassert `enable` during ACTIVE.
  - Expected: `trigger_signal` = 0 on the next edge and state = IDLE. With `enable` = 1 again and `env_in` still high, it requalifies after 4 cycles.
  - Stimulus: synchronous reset during ACTIVE.
  - Expected: all outputs 0 on the next edge, including `trig_count`.
- Counter saturation:
  - Stimulus: 17 back-to-back normal packets separated by 10 low cycles.
  - Expected: `trig_count` stops at 15.
